skin_ellipse_classifier: RTL and testbench

- Downstream consumer of the transcb/transcr nonlinear chroma-transform stages.
- Takes transformed Cb'/Cr' per pixel and applies the rotated-ellipse skin model in fixed point, producing a 1-bit skin flag.
- Pipelined with a valid strobe; also accumulates a per-frame skin-pixel count for the host/statistics block.

---
 rtl/skin_ellipse_classifier.sv | 126 ++++++++++++
 tb/tb_skin_ellipse_classifier.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/skin_ellipse_classifier.sv
// Rotated-ellipse skin classifier on transformed Cb'/Cr', 4-stage pipeline, no backpressure.
// Also counts skin pixels per frame and publishes the total on the frame's last pixel.
module skin_ellipse_classifier #(
  parameter int DATA_W = 8,
  parameter int CX     = 109,
  parameter int CY     = 152,
  parameter int COS_Q8 = -210,
  parameter int SIN_Q8 = 147,
  parameter int ECX    = 2,
  parameter int ECY    = 2,
  parameter int INV_A2 = 102,
  parameter int INV_B2 = 333,
  parameter int CNT_W  = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic              in_eof,
  input  logic [DATA_W-1:0] transcb,
  input  logic [DATA_W-1:0] transcr,
  output logic              skin_valid,
  output logic              skin,
  output logic              sof_out,
  output logic              eof_out,
  output logic [CNT_W-1:0]  frame_skin_count,
  output logic              frame_done
);

  localparam logic signed [9:0]  CX_S   = 10'(CX);
  localparam logic signed [9:0]  CY_S   = 10'(CY);
  localparam logic signed [17:0] COS_S  = 18'(COS_Q8);
  localparam logic signed [17:0] SIN_S  = 18'(SIN_Q8);
  localparam logic signed [17:0] NSIN_S = 18'(-SIN_Q8);
  localparam logic signed [11:0] ECX_S  = 12'(ECX);
  localparam logic signed [11:0] ECY_S  = 12'(ECY);
  localparam logic [29:0]        IA     = 30'(INV_A2);
  localparam logic [29:0]        IB     = 30'(INV_B2);
  localparam logic [29:0]        D_MAX  = 30'd65536;
  localparam logic [CNT_W-1:0]   CNT_MAX = '1;

  logic              v1, v2, v3;
  logic              sof1, sof2, sof3;
  logic              eof1, eof2, eof3;
  logic signed [9:0]  dcb1, dcr1;
  logic signed [11:0] x2, y2;
  logic [19:0]        sx3, sy3;
  logic [CNT_W-1:0]   acc;

  logic signed [9:0]  dcb_c, dcr_c;
  logic signed [17:0] px, py;
  logic signed [11:0] x_c, y_c;
  logic [29:0]        d_c;
  logic               skin_c;
  logic [CNT_W-1:0]   acc_next;

  always_comb begin
    dcb_c = signed'(10'(transcb)) - CX_S;
    dcr_c = signed'(10'(transcr)) - CY_S;
    px    = COS_S * 18'(dcb1) + SIN_S * 18'(dcr1);
    py    = NSIN_S * 18'(dcb1) + COS_S * 18'(dcr1);
    // >>> on a signed value floors toward -inf, matching the reference model
    x_c   = 12'(px >>> 8) - ECX_S;
    y_c   = 12'(py >>> 8) - ECY_S;
    d_c   = 30'(sx3) * IA + 30'(sy3) * IB;
    skin_c = (d_c <= D_MAX);
  end

  always_comb begin
    acc_next = acc;
    if (sof3) begin
      acc_next = {{(CNT_W-1){1'b0}}, skin_c};
    end else if (skin_c && (acc != CNT_MAX)) begin
      acc_next = acc + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0;
      sof1 <= 1'b0; sof2 <= 1'b0; sof3 <= 1'b0;
      eof1 <= 1'b0; eof2 <= 1'b0; eof3 <= 1'b0;
      dcb1 <= '0; dcr1 <= '0;
      x2 <= '0; y2 <= '0;
      sx3 <= '0; sy3 <= '0;
      skin_valid <= 1'b0;
      skin <= 1'b0;
      sof_out <= 1'b0;
      eof_out <= 1'b0;
      acc <= '0;
      frame_skin_count <= '0;
      frame_done <= 1'b0;
    end else begin
      v1   <= in_valid;
      sof1 <= in_valid & in_sof;
      eof1 <= in_valid & in_eof;
      v2 <= v1; sof2 <= sof1; eof2 <= eof1;
      v3 <= v2; sof3 <= sof2; eof3 <= eof2;
      skin_valid <= v3;
      sof_out    <= sof3;
      eof_out    <= eof3;
      frame_done <= eof3;
      if (in_valid) begin
        dcb1 <= dcb_c;
        dcr1 <= dcr_c;
      end
      if (v1) begin
        x2 <= x_c;
        y2 <= y_c;
      end
      // true square is < 2^20, so the low 20 bits of the signed product suffice
      if (v2) begin
        sx3 <= 20'(x2) * 20'(x2);
        sy3 <= 20'(y2) * 20'(y2);
      end
      if (v3) begin
        skin <= skin_c;
        acc  <= acc_next;
      end
      if (eof3) begin
        frame_skin_count <= acc_next;
      end
    end
  end

endmodule

// File: tb/tb_skin_ellipse_classifier.sv
// Directed bench for skin_ellipse_classifier; a second instance with CNT_W=3 covers saturation.
module tb_skin_ellipse_classifier;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_sof, in_eof;
  logic [7:0]  transcb, transcr;
  logic        skin_valid, skin, sof_out, eof_out, frame_done;
  logic [19:0] frame_skin_count;
  logic        s_skin_valid, s_skin, s_sof_out, s_eof_out, s_frame_done;
  logic [2:0]  s_frame_skin_count;

  int errors = 0;
  int checks = 0;

  logic h_v[4], h_s[4], h_sof[4], h_eof[4];
  int   h_cnt[4];

  always #5 clk = ~clk;

  skin_ellipse_classifier dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof), .in_eof(in_eof),
    .transcb(transcb), .transcr(transcr), .skin_valid(skin_valid), .skin(skin),
    .sof_out(sof_out), .eof_out(eof_out), .frame_skin_count(frame_skin_count),
    .frame_done(frame_done)
  );

  skin_ellipse_classifier #(.CNT_W(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof), .in_eof(in_eof),
    .transcb(transcb), .transcr(transcr), .skin_valid(s_skin_valid), .skin(s_skin),
    .sof_out(s_sof_out), .eof_out(s_eof_out), .frame_skin_count(s_frame_skin_count),
    .frame_done(s_frame_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_hist();
    for (int i = 0; i < 4; i++) begin
      h_v[i] = 1'b0; h_s[i] = 1'b0; h_sof[i] = 1'b0; h_eof[i] = 1'b0; h_cnt[i] = 0;
    end
  endtask

  // Drive one input cycle and check the pixel driven four cycles earlier.
  task automatic cyc(input logic v, input logic s, input logic e,
                     input logic [7:0] cb, input logic [7:0] cr,
                     input logic exp_skin, input int exp_cnt);
    @(negedge clk);
    chk("skin_valid", skin_valid, h_v[3]);
    chk("frame_done", frame_done, h_v[3] & h_eof[3]);
    if (h_v[3]) begin
      chk("skin", skin, h_s[3]);
      chk("sof_out", sof_out, h_sof[3]);
      chk("eof_out", eof_out, h_eof[3]);
      if (h_eof[3]) chk("frame_skin_count", frame_skin_count, h_cnt[3]);
    end
    for (int i = 3; i > 0; i--) begin
      h_v[i] = h_v[i-1]; h_s[i] = h_s[i-1]; h_sof[i] = h_sof[i-1];
      h_eof[i] = h_eof[i-1]; h_cnt[i] = h_cnt[i-1];
    end
    h_v[0] = v; h_s[0] = exp_skin; h_sof[0] = v & s; h_eof[0] = v & e; h_cnt[0] = exp_cnt;
    in_valid = v; in_sof = s; in_eof = e; transcb = cb; transcr = cr;
  endtask

  // Centre (109,152): x=-2,y=-2,d=1740 -> skin. Outside (200,152): x=-77,y=-55,d=1612083 -> not skin.
  task automatic centre(input logic s, input logic e, input int cnt);
    cyc(1'b1, s, e, 8'd109, 8'd152, 1'b1, cnt);
  endtask

  task automatic outside(input logic s, input logic e, input int cnt);
    cyc(1'b1, s, e, 8'd200, 8'd152, 1'b0, cnt);
  endtask

  task automatic flush(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_skin_valid"}, skin_valid, 0);
    chk({tag, "_skin"}, skin, 0);
    chk({tag, "_sof_out"}, sof_out, 0);
    chk({tag, "_eof_out"}, eof_out, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_frame_skin_count"}, frame_skin_count, 0);
    chk({tag, "_sat_count"}, s_frame_skin_count, 0);
  endtask

  initial begin
    clear_hist();
    rst_n = 1'b0;
    in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0; transcb = '0; transcr = '0;
    #1;
    chk_all_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // single-pixel frame, then a frame of three outside pixels
    centre(1'b1, 1'b1, 1);
    flush(3);
    outside(1'b1, 1'b0, 0);
    outside(1'b0, 1'b0, 0);
    outside(1'b0, 1'b1, 0);
    flush(5);
    chk("hold_after_outside_frame", frame_skin_count, 0);

    // ten alternating pixels with bubbles
    centre(1'b1, 1'b0, 0);
    outside(1'b0, 1'b0, 0);
    centre(1'b0, 1'b0, 0);
    flush(1);
    outside(1'b0, 1'b0, 0);
    centre(1'b0, 1'b0, 0);
    outside(1'b0, 1'b0, 0);
    flush(2);
    centre(1'b0, 1'b0, 0);
    outside(1'b0, 1'b0, 0);
    flush(1);
    centre(1'b0, 1'b0, 0);
    outside(1'b0, 1'b1, 5);
    flush(5);
    chk("hold_after_stream", frame_skin_count, 5);

    // eof with no new sof keeps counting from the last sof: 5 + 2
    centre(1'b0, 1'b0, 0);
    centre(1'b0, 1'b1, 7);
    flush(5);

    // nine skin pixels: 9 on the wide counter, 7 on the 3-bit one
    centre(1'b1, 1'b0, 0);
    for (int i = 0; i < 7; i++) centre(1'b0, 1'b0, 0);
    centre(1'b0, 1'b1, 9);
    flush(5);
    chk("sat_count", s_frame_skin_count, 7);
    chk("wide_count_hold", frame_skin_count, 9);

    // reset with a full pipeline
    centre(1'b1, 1'b0, 0);
    centre(1'b0, 1'b0, 0);
    centre(1'b0, 1'b0, 0);
    centre(1'b0, 1'b0, 0);
    @(negedge clk);
    in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
    chk("pre_reset_valid", skin_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    clear_hist();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk_all_zero("post_release");
    flush(5);

    // pixels after reset with no sof accumulate from zero
    centre(1'b0, 1'b0, 0);
    outside(1'b0, 1'b0, 0);
    centre(1'b0, 1'b1, 2);
    flush(5);
    chk("hold_after_reset_frame", frame_skin_count, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
